complex_result_vector_collector: RTL

//  Downstream of the complex matrix-by-vector stage. Captures the per-beat complex result lanes

---
 rtl/complex_result_vector_collector_pkg.sv | 38 +++
 rtl/complex_result_vector_collector_lane_capture.sv | 29 ++
 rtl/complex_result_vector_collector.sv | 113 +++++++++++
 3 files changed

// File: rtl/complex_result_vector_collector_pkg.sv
// Shared types and helpers for the complex result vector collector.
// RESULT_CONJUGATE_EN (optional) conjugates each element as it is captured.
package complex_result_vector_collector_pkg;

    localparam int unsigned element_width = 64;
    localparam int unsigned real_msb      = 63;
    localparam int unsigned real_lsb      = 32;
    localparam int unsigned imag_msb      = 31;
    localparam int unsigned imag_lsb      = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [real_msb-real_lsb:0] re;
        logic [imag_msb-imag_lsb:0] im;
    } complex_t;

    // Beats needed to cover the NI-padded vector length.
    function automatic int unsigned calc_beats(int unsigned n, int unsigned lanes, int unsigned ni);
        int unsigned additional;
        additional = ni - (n % ni);
        return (n + additional + lanes - 1) / lanes;
    endfunction

    // Negate the imaginary part by flipping its IEEE-754 sign bit.
    function automatic logic [element_width-1:0] conjugate(logic [element_width-1:0] e);
        complex_t c;
        c = e;
        c.im[imag_msb-imag_lsb] = ~c.im[imag_msb-imag_lsb];
        return c;
    endfunction

endpackage

// File: rtl/complex_result_vector_collector_lane_capture.sv
// One registered complex element slot with write enable.
// RESULT_CONJUGATE_EN stores the conjugate of the written element.
import complex_result_vector_collector_pkg::*;

module complex_result_vector_collector_lane_capture (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [element_width-1:0] d,
    output logic [element_width-1:0] q
);

    logic [element_width-1:0] d_w;

`ifdef RESULT_CONJUGATE_EN
    assign d_w = conjugate(d);
`else
    assign d_w = d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (we) begin
            q <= d_w;
        end
    end

endmodule

// File: rtl/complex_result_vector_collector.sv
// Collects per-beat complex result lanes into one vector, strips NI padding, valid/ready out.
// RESULT_CONJUGATE_EN (optional) conjugates every captured element.
import complex_result_vector_collector_pkg::*;

module complex_result_vector_collector #(
    parameter int unsigned no_of_eqn_per_cluster = 3,
    parameter int unsigned no_of_lanes           = 8,
    parameter int unsigned NI                    = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic                                           in_valid,
    input  logic [element_width*no_of_lanes-1:0]           in_data,
    output logic [element_width*no_of_eqn_per_cluster-1:0] out_vector,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic                                           busy,
    output logic                                           overflow
);

    localparam int unsigned no_of_beats = calc_beats(no_of_eqn_per_cluster, no_of_lanes, NI);
    localparam int unsigned slots       = no_of_beats * no_of_lanes;
    localparam int unsigned beat_w      = (no_of_beats > 1) ? $clog2(no_of_beats) : 1;

    state_t                   state;
    state_t                   next_state;
    logic [beat_w-1:0]        beat;
    logic                     last_beat;
    logic                     accept;
    logic [element_width-1:0] slot_q [slots];
    logic [element_width-1:0] unused_pad;

    assign last_beat = (beat == beat_w'(no_of_beats - 1));
    assign accept    = (state == COLLECT) && start && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping start aborts from any state.
    always_comb begin
        next_state = state;
        if (!start) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = COLLECT;
                COLLECT: if (in_valid && last_beat) next_state = HOLD;
                HOLD:    if (out_ready) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_valid = (state == HOLD);
        busy      = (state == COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat <= '0;
        end else if ((state != COLLECT) || !start) begin
            beat <= '0;
        end else if (in_valid) begin
            beat <= beat + beat_w'(1);
        end
    end

    // Beats arriving after the vector is complete are dropped and flagged until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && ((state == HOLD) || (state == DONE))) begin
            overflow <= 1'b1;
        end
    end

    for (genvar s = 0; s < slots; s++) begin : g_slot
        localparam int unsigned lane = s % no_of_lanes;
        localparam int unsigned bt   = s / no_of_lanes;
        logic we;
        assign we = accept && (beat == beat_w'(bt));
        complex_result_vector_collector_lane_capture u_cap (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .d     (in_data[(no_of_lanes-1-lane)*element_width +: element_width]),
            .q     (slot_q[s])
        );
    end

    for (genvar e = 0; e < no_of_eqn_per_cluster; e++) begin : g_out
        assign out_vector[(no_of_eqn_per_cluster-1-e)*element_width +: element_width] = slot_q[e];
    end

    // Padding slots are captured but never leave the block.
    always_comb begin
        unused_pad = '0;
        for (int unsigned s = no_of_eqn_per_cluster; s < slots; s++) begin
            unused_pad = unused_pad ^ slot_q[s];
        end
    end

endmodule
